// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two streaming sources, the shared output channel
// and the arbiter that owns the 2:1 mux select.
interface mux2_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             s;
  logic             gnt_a;
  logic             gnt_b;

  modport master (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, s, gnt_a, gnt_b
  );

  modport slave (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, s, gnt_a, gnt_b
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux: grants source A or B the output
// channel, owns the registered select and caps each grant at MAX_BURST transfers.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input logic                clk,
  input logic                rst_n,
  mux2_rr_arbiter_if.master  bus
);
  localparam int unsigned      CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_s, w_s_nxt;
  logic             r_last_a, w_last_a_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic             w_gnt_a, w_gnt_b;
  logic             w_out_valid, w_xfer;
  logic             w_own_valid, w_oth_valid, w_burst_end;
  logic [WIDTH-1:0] w_out_data;

  assign w_gnt_a     = (r_state == GNT_A);
  assign w_gnt_b     = (r_state == GNT_B);
  // rst_n gates the handshake so a reset cycle never completes a transfer
  assign w_out_valid = rst_n & ((w_gnt_a & bus.a_valid) | (w_gnt_b & bus.b_valid));
  assign w_xfer      = w_out_valid & bus.out_ready;
  assign w_out_data  = r_s ? bus.a_data : bus.b_data;

  assign w_own_valid = w_gnt_a ? bus.a_valid : bus.b_valid;
  assign w_oth_valid = w_gnt_a ? bus.b_valid : bus.a_valid;
  assign w_burst_end = w_xfer & (r_cnt == CNT_LAST);

  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.a_ready   = rst_n & w_gnt_a & bus.out_ready;
  assign bus.b_ready   = rst_n & w_gnt_b & bus.out_ready;
  assign bus.gnt_a     = w_gnt_a;
  assign bus.gnt_b     = w_gnt_b;
  assign bus.s         = r_s;

  // State, select, last-served and burst counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_s      <= 1'b1;
      r_last_a <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_s      <= w_s_nxt;
      r_last_a <= w_last_a_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Arbitration and burst release
  always_comb begin
    w_state_nxt  = r_state;
    w_s_nxt      = r_s;
    w_last_a_nxt = r_last_a;
    w_cnt_nxt    = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (bus.a_valid && (!bus.b_valid || !r_last_a)) begin
          w_state_nxt = GNT_A;
          w_s_nxt     = 1'b1;
          w_cnt_nxt   = '0;
        end else if (bus.b_valid) begin
          w_state_nxt = GNT_B;
          w_s_nxt     = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      GNT_A, GNT_B: begin
        if (w_burst_end || !w_own_valid) begin
          w_last_a_nxt = w_gnt_a;
          w_cnt_nxt    = '0;
          if (w_oth_valid) begin
            w_state_nxt = w_gnt_a ? GNT_B : GNT_A;
            w_s_nxt     = w_gnt_b;
          end else if (!(w_burst_end && w_own_valid)) begin
            w_state_nxt = IDLE;
          end
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: reset, single source, round-robin,
// backpressure, early release and reset mid-burst.
module tb_mux2_rr_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  mux2_rr_arbiter_if #(.WIDTH(8)) bus ();

  mux2_rr_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    logic isa;
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.a_valid   = 1'b1;
    bus.b_valid   = 1'b1;
    bus.a_data    = 8'hAA;
    bus.b_data    = 8'hBB;
    bus.out_ready = 1'b1;

    // Reset with both sources requesting
    tick();
    tick();
    settle();
    chk("rst_s",         8'(bus.s),         8'd1);
    chk("rst_gnt_a",     8'(bus.gnt_a),     8'd0);
    chk("rst_gnt_b",     8'(bus.gnt_b),     8'd0);
    chk("rst_out_valid", 8'(bus.out_valid), 8'd0);
    chk("rst_a_ready",   8'(bus.a_ready),   8'd0);
    chk("rst_b_ready",   8'(bus.b_ready),   8'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("arb_lat_gnt_a",  8'(bus.gnt_a),     8'd0);
    chk("arb_lat_valid",  8'(bus.out_valid), 8'd0);
    tick();
    settle();
    chk("first_gnt_a", 8'(bus.gnt_a), 8'd1);
    chk("first_s",     8'(bus.s),     8'd1);
    tick();

    // Single source A: eight back-to-back transfers, re-grant every four
    rst_n       = 1'b0;
    bus.b_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("single_idle", 8'(bus.out_valid), 8'd0);
    tick();
    for (int k = 0; k < 8; k++) begin
      bus.a_data = 8'h11 + 8'(k);
      settle();
      chk("single_valid", 8'(bus.out_valid), 8'd1);
      chk("single_data",  bus.out_data,      8'h11 + 8'(k));
      chk("single_s",     8'(bus.s),         8'd1);
      chk("single_gnt_b", 8'(bus.gnt_b),     8'd0);
      tick();
    end
    bus.a_valid = 1'b0;
    settle();
    chk("drop_valid", 8'(bus.out_valid), 8'd0);
    chk("drop_gnt_a", 8'(bus.gnt_a),     8'd1);
    tick();
    settle();
    chk("drop_idle", 8'(bus.gnt_a), 8'd0);
    tick();

    // Contention: 4xA, 4xB, 4xA with no bubble
    rst_n       = 1'b0;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    bus.a_data  = 8'hAA;
    bus.b_data  = 8'hBB;
    tick();
    rst_n = 1'b1;
    settle();
    chk("rr_idle", 8'(bus.out_valid), 8'd0);
    tick();
    for (int k = 0; k < 12; k++) begin
      isa = ((k / 4) % 2) == 0;
      settle();
      chk("rr_valid", 8'(bus.out_valid), 8'd1);
      chk("rr_gnt_a", 8'(bus.gnt_a),     8'(isa));
      chk("rr_s",     8'(bus.s),         8'(isa));
      chk("rr_data",  bus.out_data,      isa ? 8'hAA : 8'hBB);
      tick();
    end

    // Backpressure in the middle of a B burst
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("bp_pre_gnt_b", 8'(bus.gnt_b),   8'd1);
      chk("bp_pre_ready", 8'(bus.b_ready), 8'd1);
      tick();
    end
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("bp_stall_ready", 8'(bus.b_ready),   8'd0);
      chk("bp_stall_gnt_b", 8'(bus.gnt_b),     8'd1);
      chk("bp_stall_valid", 8'(bus.out_valid), 8'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk("bp_post_gnt_b", 8'(bus.gnt_b),   8'd1);
      chk("bp_post_ready", 8'(bus.b_ready), 8'd1);
      chk("bp_post_data",  bus.out_data,    8'hBB);
      tick();
    end
    settle();
    chk("bp_handoff_gnt_a", 8'(bus.gnt_a), 8'd1);
    chk("bp_handoff_s",     8'(bus.s),     8'd1);
    tick();

    // Early release of A after one transfer; A re-requests during B burst
    bus.a_valid = 1'b0;
    settle();
    chk("early_valid", 8'(bus.out_valid), 8'd0);
    chk("early_gnt_a", 8'(bus.gnt_a),     8'd1);
    tick();
    bus.a_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      chk("early_gnt_b", 8'(bus.gnt_b), 8'd1);
      chk("early_s",     8'(bus.s),     8'd0);
      chk("early_data",  bus.out_data,  8'hBB);
      tick();
    end
    settle();
    chk("early_back_a", 8'(bus.gnt_a), 8'd1);
    chk("early_back_s", 8'(bus.s),     8'd1);
    tick();

    // Reset during the second transfer of a B grant
    bus.a_valid = 1'b0;
    settle();
    chk("mid_rel_valid", 8'(bus.out_valid), 8'd0);
    tick();
    settle();
    chk("mid_gnt_b", 8'(bus.gnt_b), 8'd1);
    tick();
    rst_n = 1'b0;
    settle();
    chk("mid_rst_ready", 8'(bus.b_ready),   8'd0);
    chk("mid_rst_valid", 8'(bus.out_valid), 8'd0);
    tick();
    rst_n = 1'b1;
    settle();
    chk("mid_idle_gnt_b", 8'(bus.gnt_b),     8'd0);
    chk("mid_idle_s",     8'(bus.s),         8'd1);
    chk("mid_idle_valid", 8'(bus.out_valid), 8'd0);
    tick();
    settle();
    chk("mid_regnt_b", 8'(bus.gnt_b), 8'd1);
    chk("mid_regnt_s", 8'(bus.s),     8'd0);
    tick();
    bus.a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("mid_cnt_gnt_b", 8'(bus.gnt_b), 8'd1);
      tick();
    end
    settle();
    chk("mid_cnt_gnt_a", 8'(bus.gnt_a), 8'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
